// File: rtl/program_memory_responder_pkg.sv
// Shared types and defaults for the program memory responder and its byte RAM.
package program_memory_responder_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Ownership of the memory write port: loader (CPU held) or CPU.
    typedef enum logic [0:0] {
        MEM_STATE_LOAD = 1'b0,
        MEM_STATE_RUN  = 1'b1
    } memState_t;

    // State entered when leaving reset, chosen by the LOAD_ON_RESET parameter.
    function automatic memState_t resetState(input int loadOnReset);
        return (loadOnReset != 0) ? MEM_STATE_LOAD : MEM_STATE_RUN;
    endfunction

endpackage

// File: rtl/program_memory_responder_byte_ram.sv
// 1R1W synchronous byte RAM. Write-first on an address collision; the read
// register only updates when rdEn is set, so the last read value is held.
// Array contents are never reset; only the read register is cleared.
module program_memory_responder_byte_ram
    import program_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage array: plain write port, no reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read register: bypasses the write data when both ports hit the same byte.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            rdData <= '0;
        end else if (rdEn) begin
            if (wrEn && (wrAddr == rdAddr)) begin
                rdData <= wrData;
            end else begin
                rdData <= mem[rdAddr];
            end
        end
    end

endmodule

// File: rtl/program_memory_responder.sv
// Memory-side responder for the processor byte bus. Serves CPU reads and
// writes in RUN, and hands the RAM write port to a byte-stream loader in LOAD
// while holding the processor.
//
//   state          | meaning
//   ---------------+--------------------------------------------------------
//   MEM_STATE_LOAD | loader owns RAM, CPU stalled, bytes go to ram[pointer]
//   MEM_STATE_RUN  | CPU owns RAM, strobe reads / byte writes, ldStart reloads
module program_memory_responder
    import program_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int LOAD_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memStrobe,
    output logic [DATA_WIDTH-1:0] memDataRead,
    input  logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memDataWrite,
    output logic                  cpuHold,
    input  logic                  ldStart,
    input  logic                  ldValid,
    input  logic [DATA_WIDTH-1:0] ldData,
    input  logic                  ldLast,
    output logic                  ldReady,
    output logic [ADDR_WIDTH:0]   loadCount
);

    localparam memState_t             RESET_STATE = resetState(LOAD_ON_RESET);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST    = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = 1;

    memState_t             state;
    memState_t             nextState;
    logic [ADDR_WIDTH-1:0] pointer;
    logic                  ldAccept;
    logic                  restartLoad;
    logic                  ramWrEn;
    logic [ADDR_WIDTH-1:0] ramWrAddr;
    logic [DATA_WIDTH-1:0] ramWrData;
    logic                  ramRdEn;

    // State register plus the loader pointer and session byte count.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= RESET_STATE;
            pointer   <= '0;
            loadCount <= '0;
        end else begin
            state <= nextState;
            if (restartLoad) begin
                pointer   <= '0;
                loadCount <= '0;
            end else if (ldAccept) begin
                pointer   <= pointer + PTR_ONE;
                loadCount <= loadCount + COUNT_ONE;
            end
        end
    end

    // Next state and write-port ownership: loader in LOAD, CPU in RUN.
    always_comb begin
        nextState   = state;
        ldAccept    = 1'b0;
        restartLoad = 1'b0;
        ramWrEn     = 1'b0;
        ramWrAddr   = memAddr;
        ramWrData   = memDataWrite;
        unique case (state)
            MEM_STATE_LOAD: begin
                ramWrAddr = pointer;
                ramWrData = ldData;
                if (ldValid) begin
                    ldAccept = 1'b1;
                    ramWrEn  = 1'b1;
                    // The last address ends the session so a long stream can
                    // never wrap over address 0.
                    if (ldLast || (pointer == PTR_LAST)) begin
                        nextState = MEM_STATE_RUN;
                    end
                end
            end
            MEM_STATE_RUN: begin
                ramWrEn = memWrite;
                if (ldStart) begin
                    restartLoad = 1'b1;
                    nextState   = MEM_STATE_LOAD;
                end
            end
            default: begin
                nextState = RESET_STATE;
            end
        endcase
        // Reset wins over any write request presented in the same cycle.
        if (!resetN) begin
            ramWrEn = 1'b0;
        end
    end

    assign ramRdEn = memStrobe && (state == MEM_STATE_RUN);
    assign cpuHold = (state == MEM_STATE_LOAD);
    assign ldReady = (state == MEM_STATE_LOAD);

    program_memory_responder_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) uRam (
        .clk   (clk),
        .resetN(resetN),
        .wrEn  (ramWrEn),
        .wrAddr(ramWrAddr),
        .wrData(ramWrData),
        .rdEn  (ramRdEn),
        .rdAddr(memAddr),
        .rdData(memDataRead)
    );

endmodule

// File: tb/tb_program_memory_responder.sv
// Self-checking bench for program_memory_responder (LOAD_ON_RESET=1).
module tb_program_memory_responder;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] memAddr;
    logic       memStrobe;
    logic [7:0] memDataRead;
    logic       memWrite;
    logic [7:0] memDataWrite;
    logic       cpuHold;
    logic       ldStart;
    logic       ldValid;
    logic [7:0] ldData;
    logic       ldLast;
    logic       ldReady;
    logic [8:0] loadCount;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    int mMem   [DEPTH];
    bit mKnown [DEPTH];
    int mRead;
    bit mReadKnown;
    bit mHold;
    int mPtr;
    int mCount;

    always #5 clk = ~clk;

    program_memory_responder #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .LOAD_ON_RESET(1)
    ) dut (
        .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
        .memDataRead(memDataRead), .memWrite(memWrite), .memDataWrite(memDataWrite),
        .cpuHold(cpuHold), .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldLast(ldLast), .ldReady(ldReady), .loadCount(loadCount)
    );

    task automatic idle();
        resetN = 1'b1; memAddr = 8'h00; memStrobe = 1'b0; memWrite = 1'b0;
        memDataWrite = 8'h00; ldStart = 1'b0; ldValid = 1'b0; ldData = 8'h00; ldLast = 1'b0;
    endtask

    // Advance one clock edge, apply the behavioural rules to the model, then settle.
    task automatic step();
        @(posedge clk);
        if (!resetN) begin
            mHold = 1; mPtr = 0; mCount = 0; mRead = 0; mReadKnown = 1;
        end else if (mHold) begin
            if (ldValid) begin
                mMem[mPtr] = int'(ldData); mKnown[mPtr] = 1;
                mPtr = (mPtr + 1) % DEPTH;
                mCount = mCount + 1;
                if (ldLast || mCount == DEPTH) mHold = 0;
            end
        end else begin
            if (memWrite) begin
                mMem[memAddr] = int'(memDataWrite); mKnown[memAddr] = 1;
            end
            if (memStrobe) begin
                mRead = mMem[memAddr]; mReadKnown = mKnown[memAddr];
            end
            if (ldStart) begin
                mHold = 1; mPtr = 0; mCount = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); resetN = 1'b0;
        step(); step();
        nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL reset_cpuHold got %b want 1", cpuHold); end
        nChecks++; if (ldReady !== 1'b1) begin nFails++; $display("FAIL reset_ldReady got %b want 1", ldReady); end
        nChecks++; if (loadCount !== 9'd0) begin nFails++; $display("FAIL reset_loadCount got %0d want 0", loadCount); end
        nChecks++; if (memDataRead !== 8'h00) begin nFails++; $display("FAIL reset_memDataRead got %h want 00", memDataRead); end
        resetN = 1'b1;
    endtask

    task automatic test_small_load();
        logic [7:0] bytes [3];
        bytes[0] = 8'h3C; bytes[1] = 8'h11; bytes[2] = 8'hF2;
        idle();
        for (int i = 0; i < 3; i++) begin
            ldValid = 1'b1; ldData = bytes[i]; ldLast = (i == 2);
            nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL small_hold_%0d got %b want 1", i, cpuHold); end
            step();
        end
        idle();
        nChecks++; if (cpuHold !== 1'b0) begin nFails++; $display("FAIL small_release got %b want 0", cpuHold); end
        nChecks++; if (loadCount !== 9'd3) begin nFails++; $display("FAIL small_count got %0d want 3", loadCount); end
        memStrobe = 1'b1; memAddr = 8'h01;
        step(); idle();
        nChecks++; if (memDataRead !== 8'h11) begin nFails++; $display("FAIL small_read1 got %h want 11", memDataRead); end
    endtask

    task automatic test_run_rw();
        idle(); memWrite = 1'b1; memAddr = 8'h40; memDataWrite = 8'hA5;
        step();
        idle(); memStrobe = 1'b1; memAddr = 8'h40;
        step();
        nChecks++; if (memDataRead !== 8'hA5) begin nFails++; $display("FAIL rw_read40 got %h want a5", memDataRead); end
        memStrobe = 1'b1; memWrite = 1'b1; memAddr = 8'h41; memDataWrite = 8'h5A;
        step(); idle();
        nChecks++; if (memDataRead !== 8'h5A) begin nFails++; $display("FAIL rw_writefirst got %h want 5a", memDataRead); end
    endtask

    task automatic test_read_hold();
        idle(); memStrobe = 1'b1; memAddr = 8'h00;
        step(); memStrobe = 1'b0;
        nChecks++; if (memDataRead !== 8'h3C) begin nFails++; $display("FAIL hold_read0 got %h want 3c", memDataRead); end
        for (int i = 0; i < 4; i++) begin
            memAddr = 8'($urandom);
            step();
            nChecks++; if (memDataRead !== 8'h3C) begin nFails++; $display("FAIL hold_cycle%0d got %h want 3c", i, memDataRead); end
        end
    endtask

    task automatic test_full_load();
        idle(); ldStart = 1'b1;
        step(); ldStart = 1'b0;
        nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL full_start_hold got %b want 1", cpuHold); end
        nChecks++; if (loadCount !== 9'd0) begin nFails++; $display("FAIL full_start_count got %0d want 0", loadCount); end
        for (int i = 0; i < DEPTH; i++) begin
            ldValid = 1'b1; ldData = 8'(i) ^ 8'hFF; ldLast = 1'b0;
            step();
            if (i < DEPTH - 1) begin
                nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL full_hold_%0d got %b want 1", i, cpuHold); end
            end
        end
        idle();
        nChecks++; if (cpuHold !== 1'b0) begin nFails++; $display("FAIL full_release got %b want 0", cpuHold); end
        nChecks++; if (loadCount !== 9'd256) begin nFails++; $display("FAIL full_count got %0d want 256", loadCount); end
        memStrobe = 1'b1; memAddr = 8'hFF; step();
        nChecks++; if (memDataRead !== 8'h00) begin nFails++; $display("FAIL full_readFF got %h want 00", memDataRead); end
        memAddr = 8'h00; step(); idle();
        nChecks++; if (memDataRead !== 8'hFF) begin nFails++; $display("FAIL full_read00 got %h want ff", memDataRead); end
    endtask

    task automatic test_load_ignores_cpu();
        idle(); ldStart = 1'b1;
        step(); ldStart = 1'b0;
        nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL ign_start_hold got %b want 1", cpuHold); end
        nChecks++; if (loadCount !== 9'd0) begin nFails++; $display("FAIL ign_start_count got %0d want 0", loadCount); end
        memWrite = 1'b1; memStrobe = 1'b1; memAddr = 8'h10; memDataWrite = 8'h77;
        step(); idle();
        nChecks++; if (memDataRead !== 8'hFF) begin nFails++; $display("FAIL ign_read_held got %h want ff", memDataRead); end
        // ldStart during a load is ignored: count keeps going
        ldValid = 1'b1; ldData = 8'($urandom); ldStart = 1'b1;
        step(); idle();
        nChecks++; if (loadCount !== 9'd1) begin nFails++; $display("FAIL ign_ldstart_count got %0d want 1", loadCount); end
        ldLast = 1'b1;
        step(); idle();
        nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL ign_last_novalid got %b want 1", cpuHold); end
        ldValid = 1'b1; ldLast = 1'b1; ldData = 8'($urandom);
        step(); idle();
        nChecks++; if (cpuHold !== 1'b0) begin nFails++; $display("FAIL ign_release got %b want 0", cpuHold); end
        nChecks++; if (loadCount !== 9'd2) begin nFails++; $display("FAIL ign_count got %0d want 2", loadCount); end
        memStrobe = 1'b1; memAddr = 8'h10;
        step(); idle();
        nChecks++; if (memDataRead !== 8'hEF) begin nFails++; $display("FAIL ign_ram10 got %h want ef", memDataRead); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] first [5];
        logic [7:0] second [2];
        logic [7:0] expv;
        idle(); ldStart = 1'b1;
        step(); ldStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            first[i] = 8'($urandom); ldValid = 1'b1; ldData = first[i];
            step();
        end
        idle();
        nChecks++; if (loadCount !== 9'd5) begin nFails++; $display("FAIL mid_count5 got %0d want 5", loadCount); end
        resetN = 1'b0; step(); resetN = 1'b1;
        nChecks++; if (loadCount !== 9'd0) begin nFails++; $display("FAIL mid_reset_count got %0d want 0", loadCount); end
        nChecks++; if (cpuHold !== 1'b1) begin nFails++; $display("FAIL mid_reset_hold got %b want 1", cpuHold); end
        for (int i = 0; i < 2; i++) begin
            second[i] = first[i] ^ 8'h5A; ldValid = 1'b1; ldData = second[i]; ldLast = (i == 1);
            step();
        end
        idle();
        nChecks++; if (loadCount !== 9'd2) begin nFails++; $display("FAIL mid_reload_count got %0d want 2", loadCount); end
        for (int a = 0; a < 5; a++) begin
            expv = (a < 2) ? second[a] : first[a];
            memStrobe = 1'b1; memAddr = 8'(a);
            step(); idle();
            nChecks++; if (memDataRead !== expv) begin nFails++; $display("FAIL mid_read%0d got %h want %h", a, memDataRead, expv); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            resetN       = ($urandom_range(0, 59) != 0);
            memStrobe    = 1'($urandom);
            memWrite     = ($urandom_range(0, 2) == 0);
            memAddr      = 8'($urandom_range(0, 15));
            memDataWrite = 8'($urandom);
            ldStart      = ($urandom_range(0, 24) == 0);
            ldValid      = 1'($urandom);
            ldLast       = ($urandom_range(0, 5) == 0);
            ldData       = 8'($urandom);
            step();
            nChecks++; if (cpuHold !== mHold) begin nFails++; $display("FAIL rnd_cpuHold cyc %0d got %b want %b", i, cpuHold, mHold); end
            nChecks++; if (ldReady !== mHold) begin nFails++; $display("FAIL rnd_ldReady cyc %0d got %b want %b", i, ldReady, mHold); end
            nChecks++; if (loadCount !== 9'(mCount)) begin nFails++; $display("FAIL rnd_loadCount cyc %0d got %0d want %0d", i, loadCount, mCount); end
            if (mReadKnown) begin
                nChecks++; if (memDataRead !== 8'(mRead)) begin nFails++; $display("FAIL rnd_memDataRead cyc %0d got %h want %h", i, memDataRead, 8'(mRead)); end
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mMem[i] = 0; mKnown[i] = 0; end
        mRead = 0; mReadKnown = 0; mHold = 1; mPtr = 0; mCount = 0;
        idle();
        test_reset();
        test_small_load();
        test_run_rw();
        test_read_hold();
        test_full_load();
        test_load_ignores_cpu();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
